motor_ramp_sequencer: RTL and testbench
=======================================

Name: motor_ramp_sequencer

Overview:
AXI4-Lite master that sequences the motor controller IP register file so commanded speed changes are applied as a bounded-rate ramp. Accepts a target duty/direction from the control logic and steps the applied duty toward it once per ramp tick, writing each step to the motor controller's duty register. A direction reversal ramps duty to 0, writes the direction register, then ramps back up. Sits between the PS-side control logic and the motor controller's S00_AXI port.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
BASE_ADDR, 32'h0000_0000, motor controller base address
DUTY_W, 16, duty command width (<= 32)
STEP, 16, maximum duty change per tick
RAMP_DIV, 1000, ACLK cycles per ramp tick (>= 2)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
tgt_valid  in  1  new target strobe
tgt_ready  out  1  target accepted when high with tgt_valid
tgt_duty  in  DUTY_W  target duty
tgt_dir  in  1  target direction
err_clr  in  1  clears bresp_err
cur_duty  out  DUTY_W  last duty issued to the motor controller
cur_dir  out  1  last direction issued to the motor controller
busy  out  1  ramp or write in progress
bresp_err  out  1  sticky: a write returned non-OKAY
M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  constant 3'b000
M_AXI_AWVALID  out  1  address valid
M_AXI_AWREADY  in  1  address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  constant 4'hF
M_AXI_WVALID  out  1  data valid
M_AXI_WREADY  in  1  data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  response valid
M_AXI_BREADY  out  1  response ready

Behaviour:
- Reset (ARESETN low, asynchronous): all outputs 0 except tgt_ready=1. Target regs, cur_duty, cur_dir, tick counter, pending-tick flag and FSM all cleared. Any in-flight AXI valid drops immediately. Reset does not complete the in-flight write; the slave must share the reset.
- Target capture: tgt_ready is constantly 1 out of reset. On tgt_valid, tgt_duty/tgt_dir are latched next edge. The latest target wins; no queueing.
- Tick: counter runs 0..RAMP_DIV-1 continuously. Tick pulses on wrap. A tick arriving while the FSM is not IDLE sets pending_tick (saturating, one deep). pending_tick is consumed on return to IDLE.
- Step decision (IDLE with tick or pending_tick):
  - dir mismatch and cur_duty>0: next duty = max(cur_duty-STEP, 0); issue DUTY write.
  - dir mismatch and cur_duty==0: issue DIR write (no tick needed; issued from IDLE immediately).
  - dir match and cur_duty!=tgt_duty: move toward target by STEP, clamped to target; issue DUTY write.
  - otherwise: no write.
- Register map (offset from BASE_ADDR):
  - 0x0 DUTY: WDATA = duty zero-extended.
  - 0x4 DIR: WDATA = {31'b0, dir}.
- FSM states: IDLE -> WR_AW_W -> WR_B -> IDLE.
  - WR_AW_W is entered the cycle after the decision. AWVALID and WVALID rise together. Each drops independently the cycle after its own ready handshake. Once both are done, go to WR_B.
  - WR_B: BREADY=1 until BVALID is sampled, then IDLE.
  - cur_duty/cur_dir update on entry to WR_AW_W, i.e. when the write launches.
- Latency: tick at edge N gives AWVALID=WVALID=1 after edge N+1. Zero-wait slave: minimum 3 cycles per write.
- bresp_err: set when BVALID&&BREADY&&BRESP!=2'b00. Cleared by err_clr. Set wins if both occur in the same cycle. Sequencing continues after an error.
- busy = (FSM!=IDLE) || (cur_duty!=tgt_duty) || (cur_dir!=tgt_dir).
- AWADDR/WDATA stay stable while the corresponding valid is high (AXI rule).

Test Plan:
Bench settings for all scenarios: RAMP_DIV=4, STEP=16.
1. Hold ARESETN low 20 cycles, then release with no targets -> all valids stay 0, busy=0, cur_duty=0, tgt_ready=1.
2. Target duty 40, dir 0, zero-wait slave -> DUTY writes to 0x0 with data 16, 32, 40, one per tick. busy falls after the third B handshake.
3. From duty 40/dir 0, target duty 20/dir 1 -> writes 0x0:24, 0x0:8, 0x0:0, then 0x4:1, then 0x0:16, 0x0:20. cur_dir=1 at end.
4. AWREADY delayed 3 cycles, WREADY immediate -> WVALID high exactly 1 cycle, AWVALID held 4 cycles with stable AWADDR. Ticks during the stall produce exactly one extra write afterwards.
5. BRESP=2'b10 on the second write -> bresp_err=1 and held; ramp still completes. err_clr pulse -> 0. err_clr coincident with a new error -> stays 1.
6. ARESETN asserted while AWVALID=1 -> AWVALID, WVALID and cur_duty go 0 immediately. After release with the target reapplied, the ramp restarts from 0 (first write 0x0:16).

Source files
------------

// File: rtl/motor_ramp_sequencer.sv
// AXI4-Lite master that moves the motor controller's duty register toward a commanded
// target one bounded step per ramp tick. A reversal ramps to zero before the direction is written.
module motor_ramp_sequencer #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter int          DUTY_W             = 16,
  parameter int          STEP               = 16,
  parameter int          RAMP_DIV           = 1000
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              tgt_valid,
  output logic                              tgt_ready,
  input  logic [DUTY_W-1:0]                 tgt_duty,
  input  logic                              tgt_dir,
  input  logic                              err_clr,
  output logic [DUTY_W-1:0]                 cur_duty,
  output logic                              cur_dir,
  output logic                              busy,
  output logic                              bresp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int CNT_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
  localparam logic [AW-1:0]     DUTY_ADDR = AW'(BASE_ADDR);
  localparam logic [AW-1:0]     DIR_ADDR  = AW'(BASE_ADDR) + AW'(4);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_AW_W = 2'd1,
    WR_B    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              pend_q, pend_d;
  logic [DUTY_W-1:0] tgt_duty_q, tgt_duty_d;
  logic              tgt_dir_q, tgt_dir_d;
  logic [DUTY_W-1:0] cur_duty_q, cur_duty_d;
  logic              cur_dir_q, cur_dir_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [AW-1:0]     awaddr_q, awaddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              dir_mismatch;
  logic [DUTY_W-1:0] duty_down;
  logic [DUTY_W-1:0] duty_toward;

  // Candidate next duty values: toward zero for a reversal, toward the target otherwise.
  always_comb begin
    dir_mismatch = (cur_dir_q != tgt_dir_q);
    duty_down    = (cur_duty_q > STEP_D) ? (cur_duty_q - STEP_D) : '0;
    if (cur_duty_q < tgt_duty_q) begin
      duty_toward = ((tgt_duty_q - cur_duty_q) > STEP_D) ? (cur_duty_q + STEP_D) : tgt_duty_q;
    end else begin
      duty_toward = ((cur_duty_q - tgt_duty_q) > STEP_D) ? (cur_duty_q - STEP_D) : tgt_duty_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : (cnt_q + CNT_W'(1));
    tick_d     = (cnt_q == CNT_LAST);
    pend_d     = pend_q;
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    cur_duty_d = cur_duty_q;
    cur_dir_d  = cur_dir_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    if (tgt_valid) begin
      tgt_duty_d = tgt_duty;
      tgt_dir_d  = tgt_dir;
    end

    // Set is evaluated last so a new error beats a simultaneous clear.
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (M_AXI_BVALID && bready_q && (M_AXI_BRESP != 2'b00)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (dir_mismatch && (cur_duty_q == '0)) begin
          state_d   = WR_AW_W;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = DIR_ADDR;
          wdata_d   = DW'(tgt_dir_q);
          cur_dir_d = tgt_dir_q;
        end else if (tick_q || pend_q) begin
          pend_d = 1'b0;
          if (dir_mismatch) begin
            state_d    = WR_AW_W;
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
            awaddr_d   = DUTY_ADDR;
            wdata_d    = DW'(duty_down);
            cur_duty_d = duty_down;
          end else if (cur_duty_q != tgt_duty_q) begin
            state_d    = WR_AW_W;
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
            awaddr_d   = DUTY_ADDR;
            wdata_d    = DW'(duty_toward);
            cur_duty_d = duty_toward;
          end
        end
      end
      WR_AW_W: begin
        if (tick_q) begin
          pend_d = 1'b1;
        end
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (tick_q) begin
          pend_d = 1'b1;
        end
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      pend_q     <= 1'b0;
      tgt_duty_q <= '0;
      tgt_dir_q  <= 1'b0;
      cur_duty_q <= '0;
      cur_dir_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
      cur_duty_q <= cur_duty_d;
      cur_dir_q  <= cur_dir_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign tgt_ready     = 1'b1;
  assign cur_duty      = cur_duty_q;
  assign cur_dir       = cur_dir_q;
  assign busy          = (state_q != IDLE) || (cur_duty_q != tgt_duty_q) || (cur_dir_q != tgt_dir_q);
  assign bresp_err     = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: a behavioural AXI4-Lite slave logs every
// handshake, and the main sequence compares the logged writes against hand-computed ramps.
module tb_motor_ramp_sequencer;

  logic        ACLK;
  logic        ARESETN;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [15:0] tgt_duty;
  logic        tgt_dir;
  logic        err_clr;
  logic [15:0] cur_duty;
  logic        cur_dir;
  logic        busy;
  logic        bresp_err;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  int checks   = 0;
  int failures = 0;

  int aw_delay = 0;
  int w_delay  = 0;
  int bad_idx  = -1;
  int b_count  = 0;
  int aw_run   = 0;
  int w_run    = 0;
  logic [31:0] aw_first;
  logic [31:0] w_first;
  logic        addr_moved = 1'b0;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int          aw_len_log[$];
  int          w_len_log[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  motor_ramp_sequencer #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .BASE_ADDR(32'h0000_0000),
    .DUTY_W(16),
    .STEP(16),
    .RAMP_DIV(4)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_duty(tgt_duty),
    .tgt_dir(tgt_dir),
    .err_clr(err_clr),
    .cur_duty(cur_duty),
    .cur_dir(cur_dir),
    .busy(busy),
    .bresp_err(bresp_err),
    .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Slave decides its ready/response at each falling edge; a handshake it grants there
  // completes on the following rising edge, so it is logged at the same time.
  initial begin
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    forever begin
      @(negedge ACLK);
      if (M_AXI_AWVALID) begin
        if (aw_run == 0) aw_first = M_AXI_AWADDR;
        else if (M_AXI_AWADDR !== aw_first) addr_moved = 1'b1;
        M_AXI_AWREADY = (aw_run >= aw_delay);
        aw_run++;
        if (M_AXI_AWREADY) aw_log.push_back(M_AXI_AWADDR);
      end else begin
        if (aw_run > 0) aw_len_log.push_back(aw_run);
        aw_run        = 0;
        M_AXI_AWREADY = 1'b0;
      end
      if (M_AXI_WVALID) begin
        if (w_run == 0) w_first = M_AXI_WDATA;
        else if (M_AXI_WDATA !== w_first) addr_moved = 1'b1;
        M_AXI_WREADY = (w_run >= w_delay);
        w_run++;
        if (M_AXI_WREADY) w_log.push_back(M_AXI_WDATA);
      end else begin
        if (w_run > 0) w_len_log.push_back(w_run);
        w_run        = 0;
        M_AXI_WREADY = 1'b0;
      end
      if (M_AXI_BREADY && !M_AXI_BVALID) begin
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (b_count == bad_idx) ? 2'b10 : 2'b00;
        b_count++;
      end else begin
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tickWait();
    @(negedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] duty, input logic dir);
    tgt_valid = 1'b1;
    tgt_duty  = duty;
    tgt_dir   = dir;
    tickWait();
    tgt_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      tickWait();
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clearLogs();
    aw_log.delete();
    w_log.delete();
    aw_len_log.delete();
    w_len_log.delete();
    exp_a.delete();
    exp_d.delete();
    addr_moved = 1'b0;
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic checkLog(input string tag);
    checkOutput({tag, "_naw"}, 32'(aw_log.size()), 32'(exp_a.size()));
    checkOutput({tag, "_nw"}, 32'(w_log.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_a.size() && i < aw_log.size(); i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), aw_log[i], exp_a[i]);
    for (int i = 0; i < exp_d.size() && i < w_log.size(); i++)
      checkOutput($sformatf("%s_data%0d", tag, i), w_log[i], exp_d[i]);
  endtask

  initial begin
    int n;
    int b_base;
    ARESETN   = 1'b0;
    tgt_valid = 1'b0;
    tgt_duty  = '0;
    tgt_dir   = 1'b0;
    err_clr   = 1'b0;

    $display("[TB] scenario 1: reset and idle");
    repeat (20) tickWait();
    checkOutput("rst_tgt_ready", 32'(tgt_ready), 32'd1);
    checkOutput("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
    checkOutput("rst_bready", 32'(M_AXI_BREADY), 32'd0);
    ARESETN = 1'b1;
    repeat (12) tickWait();
    checkOutput("idle_awvalid", 32'(M_AXI_AWVALID), 32'd0);
    checkOutput("idle_wvalid", 32'(M_AXI_WVALID), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_cur_duty", 32'(cur_duty), 32'd0);
    checkOutput("idle_tgt_ready", 32'(tgt_ready), 32'd1);
    checkOutput("idle_awprot", 32'(M_AXI_AWPROT), 32'd0);
    checkOutput("idle_wstrb", 32'(M_AXI_WSTRB), 32'hF);
    checkOutput("idle_no_writes", 32'(aw_len_log.size() + w_len_log.size()), 32'd0);

    $display("[TB] scenario 2: ramp up to 40");
    clearLogs();
    applyStimulus(16'd40, 1'b0);
    checkOutput("s2_busy_start", 32'(busy), 32'd1);
    waitIdle("s2");
    expectWrite(32'h0, 32'd16);
    expectWrite(32'h0, 32'd32);
    expectWrite(32'h0, 32'd40);
    checkLog("s2");
    checkOutput("s2_cur_duty", 32'(cur_duty), 32'd40);
    checkOutput("s2_bresp_err", 32'(bresp_err), 32'd0);

    $display("[TB] scenario 3: reversal to 20 dir 1");
    clearLogs();
    applyStimulus(16'd20, 1'b1);
    waitIdle("s3");
    expectWrite(32'h0, 32'd24);
    expectWrite(32'h0, 32'd8);
    expectWrite(32'h0, 32'd0);
    expectWrite(32'h4, 32'd1);
    expectWrite(32'h0, 32'd16);
    expectWrite(32'h0, 32'd20);
    checkLog("s3");
    checkOutput("s3_cur_dir", 32'(cur_dir), 32'd1);
    checkOutput("s3_cur_duty", 32'(cur_duty), 32'd20);

    $display("[TB] scenario 4: AWREADY stalled 3 cycles");
    clearLogs();
    aw_delay = 3;
    applyStimulus(16'd52, 1'b1);
    waitIdle("s4");
    repeat (12) tickWait();
    expectWrite(32'h0, 32'd36);
    expectWrite(32'h0, 32'd52);
    checkLog("s4");
    checkOutput("s4_n_awlen", 32'(aw_len_log.size()), 32'd2);
    for (int i = 0; i < aw_len_log.size(); i++)
      checkOutput($sformatf("s4_awvalid_len%0d", i), 32'(aw_len_log[i]), 32'd4);
    for (int i = 0; i < w_len_log.size(); i++)
      checkOutput($sformatf("s4_wvalid_len%0d", i), 32'(w_len_log[i]), 32'd1);
    checkOutput("s4_stable", 32'(addr_moved), 32'd0);
    aw_delay = 0;

    $display("[TB] scenario 5: error response");
    clearLogs();
    b_base  = b_count;
    bad_idx = b_count + 1;
    applyStimulus(16'd100, 1'b1);
    n = 0;
    while (b_count < b_base + 2 && n < 200) begin
      tickWait();
      n++;
    end
    tickWait();
    checkOutput("s5_err_set", 32'(bresp_err), 32'd1);
    waitIdle("s5");
    checkOutput("s5_err_held", 32'(bresp_err), 32'd1);
    expectWrite(32'h0, 32'd68);
    expectWrite(32'h0, 32'd84);
    expectWrite(32'h0, 32'd100);
    checkLog("s5");
    err_clr = 1'b1;
    tickWait();
    err_clr = 1'b0;
    checkOutput("s5_err_clr", 32'(bresp_err), 32'd0);
    bad_idx = b_count;
    applyStimulus(16'd116, 1'b1);
    n = 0;
    while (!M_AXI_BVALID && n < 200) begin
      tickWait();
      n++;
    end
    checkOutput("s5_bvalid_seen", 32'(M_AXI_BVALID), 32'd1);
    err_clr = 1'b1;
    tickWait();
    err_clr = 1'b0;
    checkOutput("s5_set_wins", 32'(bresp_err), 32'd1);
    waitIdle("s5b");
    bad_idx = -1;

    $display("[TB] scenario 6: reset during write");
    aw_delay = 100;
    w_delay  = 100;
    applyStimulus(16'd200, 1'b1);
    n = 0;
    while (!M_AXI_AWVALID && n < 200) begin
      tickWait();
      n++;
    end
    checkOutput("s6_awvalid_up", 32'(M_AXI_AWVALID), 32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    checkOutput("s6_awvalid_drop", 32'(M_AXI_AWVALID), 32'd0);
    checkOutput("s6_wvalid_drop", 32'(M_AXI_WVALID), 32'd0);
    checkOutput("s6_cur_duty_drop", 32'(cur_duty), 32'd0);
    checkOutput("s6_cur_dir_drop", 32'(cur_dir), 32'd0);
    checkOutput("s6_err_drop", 32'(bresp_err), 32'd0);
    aw_delay = 0;
    w_delay  = 0;
    repeat (3) tickWait();
    clearLogs();
    ARESETN = 1'b1;
    tickWait();
    applyStimulus(16'd40, 1'b0);
    waitIdle("s6");
    expectWrite(32'h0, 32'd16);
    expectWrite(32'h0, 32'd32);
    expectWrite(32'h0, 32'd40);
    checkLog("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
